// File: rtl/div16s8s_pkg.sv
// Shared types and constants for the 16-by-8 signed restoring divider.
package div16s8s_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITERATIONS = 16;
    localparam int CNT_W      = 4;
    localparam int REM_W      = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
    function automatic logic [DIVIDEND_W-1:0] abs_dividend(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 16'd1) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs_divisor(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_restoring_step
    import div16s8s_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] dvs_mag,
    output logic [REM_W-1:0]     rem_out,
    output logic                 q_bit
);

    logic [REM_W:0] shifted_s;
    logic [REM_W:0] trial_s;

    // The top bit of the widened difference is the borrow of the trial subtraction.
    always_comb begin
        shifted_s = {rem_in, dvd_bit};
        trial_s   = shifted_s - {2'b00, dvs_mag};
        if (trial_s[REM_W]) begin
            q_bit   = 1'b0;
            rem_out = shifted_s[REM_W-1:0];
        end else begin
            q_bit   = 1'b1;
            rem_out = trial_s[REM_W-1:0];
        end
    end

endmodule

// File: rtl/div16s8s_restoring.sv
// Multi-cycle 16/8 signed truncating divider; one restoring step per cycle.
// Define DIV16S8S_OVERFLOW_DETECT_EN to flag quotients outside [-128,127].
module div16s8s_restoring
    import div16s8s_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    state_e                state_r;
    state_e                next_state_s;
    logic [DIVIDEND_W-1:0] q_r;
    logic [REM_W-1:0]      rem_r;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic                  neg_q_r;
    logic                  neg_r_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [7:0]            quotient_r;
    logic [7:0]            remainder_r;
    logic                  dbz_r;

    logic                  load_s;
    logic                  load_zero_s;
    logic                  iter_s;
    logic                  fix_s;
    logic [REM_W-1:0]      step_rem_s;
    logic                  step_q_s;
    logic [7:0]            q_fix_s;
    logic [7:0]            r_fix_s;

    div_restoring_step u_step (
        .rem_in  (rem_r),
        .dvd_bit (q_r[DIVIDEND_W-1]),
        .dvs_mag (dvs_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (divisor == 8'd0) ? DONE : CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_W'(ITERATIONS - 1)) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        load_s      = 1'b0;
        load_zero_s = 1'b0;
        iter_s      = 1'b0;
        fix_s       = 1'b0;
        case (state_r)
            IDLE: begin
                load_s      = start && (divisor != 8'd0);
                load_zero_s = start && (divisor == 8'd0);
            end
            CALC:    iter_s = 1'b1;
            FIX:     fix_s  = 1'b1;
            DONE:    fix_s  = 1'b0;
            default: fix_s  = 1'b0;
        endcase
    end

    // Sign correction; only the low 8 bits of the magnitudes survive.
    always_comb begin
        q_fix_s = neg_q_r ? (~q_r[7:0] + 8'd1) : q_r[7:0];
        r_fix_s = neg_r_r ? (~rem_r[7:0] + 8'd1) : rem_r[7:0];
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r         <= 16'd0;
            rem_r       <= 9'd0;
            dvs_r       <= 8'd0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            cnt_r       <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 8'd0;
            remainder_r <= 8'd0;
            dbz_r       <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (state_r == DONE);
            if (load_s) begin
                q_r     <= abs_dividend(dividend);
                rem_r   <= 9'd0;
                dvs_r   <= abs_divisor(divisor);
                neg_q_r <= dividend[15] ^ divisor[7];
                neg_r_r <= dividend[15];
                cnt_r   <= 4'd0;
                dbz_r   <= 1'b0;
            end else if (load_zero_s) begin
                quotient_r  <= 8'hFF;
                remainder_r <= dividend[7:0];
                dbz_r       <= 1'b1;
            end else if (iter_s) begin
                q_r   <= {q_r[DIVIDEND_W-2:0], step_q_s};
                rem_r <= step_rem_s;
                cnt_r <= cnt_r + 4'd1;
            end else if (fix_s) begin
                quotient_r  <= q_fix_s;
                remainder_r <= r_fix_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef DIV16S8S_OVERFLOW_DETECT_EN
    logic overflow_r;
    logic ovf_s;

    // A negative quotient may reach magnitude 128, a positive one only 127.
    always_comb begin
        if (neg_q_r) begin
            ovf_s = (q_r > 16'd128);
        end else begin
            ovf_s = (q_r > 16'd127);
        end
    end

    // Overflow flag: cleared on accept, evaluated during sign correction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (load_s || load_zero_s) begin
            overflow_r <= 1'b0;
        end else if (fix_s) begin
            overflow_r <= ovf_s;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: doc/div16s8s_restoring.md
DIV16S8S_RESTORING -- requirements
Module: div16s8s_restoring

Interface
REQ-001 SHALL have these ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have these ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have these ports: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have these ports: dividend  input  16  signed two's-complement; sampled with start.
REQ-005 SHALL have these ports: divisor  input  8  signed two's-complement; sampled with start.
REQ-006 SHALL have these ports: busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have these ports: done  output  1  one-cycle pulse; results are valid.
REQ-008 SHALL have these ports: quotient  output  8  signed result; held until the next accept.
REQ-009 SHALL have these ports: remainder  output  8  signed result; held until the next accept.
REQ-010 SHALL have these ports: div_by_zero  output  1  status; valid with done and held.
REQ-011 SHALL have these ports: overflow  output  1  status; valid with done and held.

Function
REQ-012 SHALL compute a truncating signed divide (quotient rounded toward zero); remainder sign SHALL equal the dividend sign; dividend = quotient*divisor + remainder whenever overflow=0.
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 Transition IDLE->CALC SHALL occur on edge N when start=1 and divisor!=0; on that edge the FSM SHALL latch the operand magnitudes and signs.
REQ-015 CALC SHALL run exactly 16 restoring iterations, one per cycle, over a 16-bit magnitude quotient and a 9-bit partial remainder; CALC->FIX SHALL occur after the 16th iteration.
REQ-016 FIX SHALL apply sign correction, truncate the quotient to 8 bits, and evaluate overflow; FIX->DONE SHALL follow.
REQ-017 done SHALL rise at edge N+18 for exactly one cycle; DONE->IDLE SHALL occur unconditionally.
REQ-018 busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 start=1 with divisor=0 in IDLE SHALL go IDLE->DONE, with done at edge N+1 and outputs quotient=8'hFF, remainder=dividend[7:0], div_by_zero=1, overflow=0.
REQ-021 div_by_zero and overflow SHALL be cleared on every accepted start.
REQ-022 Remainder magnitude is always <= 127 and SHALL need no saturation.

Reset
REQ-023 Assertion of rst SHALL asynchronously force state=IDLE and busy, done, quotient, remainder, div_by_zero and overflow to 0.
REQ-024 rst asserted mid-CALC or mid-FIX SHALL abort the operation without producing done; the first start after deassertion SHALL behave as from power-up.

Configuration
REQ-025 Macro DIV16S8S_OVERFLOW_DETECT_EN defined: overflow SHALL be 1 when the true quotient lies outside [-128,127]; quotient SHALL be the low 8 bits of the true quotient.
REQ-026 Macro DIV16S8S_OVERFLOW_DETECT_EN undefined: overflow SHALL be tied to 0 and no detection logic SHALL exist; quotient SHALL be identical to the defined case.

Structure
REQ-027 Package div16s8s_pkg SHALL hold the FSM state enum, DIVIDEND_W=16, DIVISOR_W=8 and ITERATIONS=16.
REQ-028 One sub-module div_restoring_step SHALL exist: combinational shift, trial-subtract and select for one iteration, instantiated once and reused every cycle.
REQ-029 Total RTL SHALL be approximately 150-250 lines.

Verification
REQ-030 100/7, start at edge N -> done at N+18, quotient=8'h0E, remainder=8'h02, flags 0.
REQ-031 -100/7 -> quotient=8'hF2, remainder=8'hFE; 1000/-8 -> quotient=8'h83, remainder=8'h00.
REQ-032 300/2 -> with EN: overflow=1, quotient=8'h96; without EN: overflow=0, quotient=8'h96.
REQ-033 55/0 -> done at N+1, div_by_zero=1, quotient=8'hFF, remainder=8'h37, busy high for one cycle.
REQ-034 start pulsed again at N+5 during CALC -> ignored, and the first result is unchanged at N+18.
REQ-035 rst at CALC iteration 8 -> all outputs read 0 immediately and no done follows; next start with -32768/-1 -> with EN: overflow=1, quotient=8'h00, remainder=8'h00.
